// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
// Control FSM for a multicycle RISC-V style datapath. Each instruction is
// executed as FETCH -> DECODE -> class-specific states. A bounded wait counter
// guards every memory phase. An illegal opcode or a memory timeout sends the
// unit to an absorbing TRAP state that only rst can leave.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   start      in   begin / continue instruction execution
//   opcode     in   [6:0] instruction opcode, valid from DECODE onward
//   zero       in   ALU zero flag (branch condition)
//   mem_ready  in   memory transfer completes this cycle
//   PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, MemtoReg,
//   ALUSrcA, Branch  out  single-bit datapath controls
//   ALUSrcB    out  [1:0] 00 reg B, 01 const 4, 10 immediate
//   ALUOp      out  [ALUOP_W-1:0] 0 add, 1 sub, 2 funct-decoded
//   busy       out  executing (state is neither IDLE nor TRAP)
//   illegal    out  sticky flag: trapped on an unknown opcode
//   timeout    out  sticky flag: trapped on a memory wait limit
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
   parameter int ALUOP_W  = 2,
   parameter int WAIT_W   = 4,
   parameter int MAX_WAIT = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [6:0]         opcode,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               IRWrite,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IorD,
   output logic               RegWrite,
   output logic               MemtoReg,
   output logic               ALUSrcA,
   output logic               Branch,
   output logic [1:0]         ALUSrcB,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               busy,
   output logic               illegal,
   output logic               timeout
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [ALUOP_W-1:0] ALUOP_ADD   = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALUOP_SUB   = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = ALUOP_W'(2);

   // Last count value that still allows one more waiting cycle; a cycle spent
   // at this value without mem_ready reaches the limit.
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR,
      S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_R_WB, S_TRAP
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [WAIT_W-1:0] r_wait;
   logic              r_illegal;
   logic              r_timeout;
   logic              w_set_illegal;
   logic              w_set_timeout;
   logic              w_wait_state;
   logic              w_limit;
   state_t            w_done;

   assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                         (r_state == S_MEM_WR);
   // mem_ready in the limit cycle wins, so the limit only fires without it.
   assign w_limit      = (r_wait == WAIT_LAST) && !mem_ready;
   assign w_done       = start ? S_FETCH : S_IDLE;

   assign busy    = (r_state != S_IDLE) && (r_state != S_TRAP);
   assign illegal = r_illegal;
   assign timeout = r_timeout;

   always_comb begin
      // NOTE: every output and next-state signal gets a default before the
      // case so that no path leaves a value unassigned (which would infer a latch).
      w_next        = r_state;
      w_set_illegal = 1'b0;
      w_set_timeout = 1'b0;
      PCWrite       = 1'b0;
      IRWrite       = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      IorD          = 1'b0;
      RegWrite      = 1'b0;
      MemtoReg      = 1'b0;
      ALUSrcA       = 1'b0;
      Branch        = 1'b0;
      ALUSrcB       = 2'b00;
      ALUOp         = ALUOP_ADD;

      case (r_state)
         S_IDLE: begin
            if (start) w_next = S_FETCH;
         end
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready) begin
               w_next = S_DECODE;
            end else if (w_limit) begin
               w_next        = S_TRAP;
               w_set_timeout = 1'b1;
            end
         end
         S_DECODE: begin
            ALUSrcB = 2'b10;
            case (opcode)
               OP_R:               w_next = S_EXEC_R;
               OP_I:               w_next = S_EXEC_I;
               OP_LOAD, OP_STORE:  w_next = S_MEM_ADDR;
               OP_BRANCH:          w_next = S_BRANCH;
               default: begin
                  w_next        = S_TRAP;
                  w_set_illegal = 1'b1;
               end
            endcase
         end
         S_EXEC_R: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_FUNCT;
            w_next  = S_R_WB;
         end
         S_EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALUOp   = ALUOP_FUNCT;
            w_next  = S_R_WB;
         end
         S_R_WB: begin
            RegWrite = 1'b1;
            w_next   = w_done;
         end
         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            // opcode is still held here, so it selects load versus store.
            w_next  = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) begin
               w_next = S_MEM_WB;
            end else if (w_limit) begin
               w_next        = S_TRAP;
               w_set_timeout = 1'b1;
            end
         end
         S_MEM_WB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
            w_next   = w_done;
         end
         S_MEM_WR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ready) begin
               w_next = w_done;
            end else if (w_limit) begin
               w_next        = S_TRAP;
               w_set_timeout = 1'b1;
            end
         end
         S_BRANCH: begin
            Branch  = 1'b1;
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_SUB;
            PCWrite = zero;
            w_next  = w_done;
         end
         S_TRAP: begin
            w_next = S_TRAP;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_wait    <= '0;
         r_illegal <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples the pre-edge values regardless of statement order.
         r_state <= w_next;
         // Counting only while a wait state is held; any entry clears it.
         if (w_wait_state && (w_next == r_state)) r_wait <= r_wait + 1'b1;
         else                                     r_wait <= '0;
         if (w_set_illegal) r_illegal <= 1'b1;
         if (w_set_timeout) r_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
// Randomized self-checking bench. Each instruction is expanded, from the
// instruction-class rules, into the list of per-cycle input values and the
// expected control word for that cycle; the list is then played against the
// DUT and every cycle is compared.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

   localparam int MAX_WAIT = 10;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_BAD    = 7'b1111111;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, MemtoReg;
   logic       ALUSrcA, Branch, busy, illegal, timeout;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;

   multicycle_control_unit #(
      .ALUOP_W  (2),
      .WAIT_W   (4),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .opcode    (opcode),
      .zero      (zero),
      .mem_ready (mem_ready),
      .PCWrite   (PCWrite),
      .IRWrite   (IRWrite),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .IorD      (IorD),
      .RegWrite  (RegWrite),
      .MemtoReg  (MemtoReg),
      .ALUSrcA   (ALUSrcA),
      .Branch    (Branch),
      .ALUSrcB   (ALUSrcB),
      .ALUOp     (ALUOp),
      .busy      (busy),
      .illegal   (illegal),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   // Observed control word, same field order as ev() below.
   logic [15:0] obs;
   assign obs = {PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, MemtoReg,
                 ALUSrcA, Branch, ALUSrcB, ALUOp, busy, illegal, timeout};

   typedef struct {
      string       tag;
      logic        st;
      logic        mr;
      logic        z;
      logic [6:0]  op;
      logic [15:0] exp;
   } step_t;

   step_t q[$];
   int    n_total = 0;
   int    n_bad   = 0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
      end
   endtask

   function automatic logic [15:0] ev(
      input logic pcw, input logic irw, input logic mrd, input logic mwr,
      input logic iord, input logic rw, input logic m2r, input logic srca,
      input logic br, input logic [1:0] srcb, input logic [1:0] aop,
      input logic bsy, input logic ill, input logic to);
      return {pcw, irw, mrd, mwr, iord, rw, m2r, srca, br, srcb, aop, bsy, ill, to};
   endfunction

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   function automatic void push(input string tag, input logic st, input logic mr,
                                input logic z, input logic [6:0] op,
                                input logic [15:0] e);
      step_t s;
      s.tag = tag; s.st = st; s.mr = mr; s.z = z; s.op = op; s.exp = e;
      q.push_back(s);
   endfunction

   // Trap: all controls low, not busy, cause flags held whatever the inputs do.
   function automatic void push_trap(input logic ill, input logic to);
      for (int i = 0; i < 4; i++)
         push("trap", rb(), rb(), rb(), 7'($urandom),
              ev(0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,ill,to));
   endfunction

   // Idle cycle that raises start: expected outputs all zero.
   function automatic void push_idle(input logic st);
      push("idle", st, rb(), rb(), 7'($urandom), 16'h0000);
   endfunction

   // Expand one instruction into cycles. fw/mw are the mem_ready-low cycles in
   // the fetch and memory phases; reaching MAX_WAIT of them ends in a timeout.
   // nxt is the start value at completion (0 -> some idle cycles follow).
   function automatic void gen_instr(input logic [6:0] op, input int fw, input int mw,
                                     input logic z, input logic nxt);
      for (int i = 0; i < fw && i < MAX_WAIT; i++)
         push("fetch_wait", rb(), 1'b0, rb(), op, ev(0,0,1,0,0,0,0,0,0,2'b01,2'b00,1,0,0));
      if (fw >= MAX_WAIT) begin
         push_trap(1'b0, 1'b1);
         return;
      end
      push("fetch", rb(), 1'b1, rb(), op, ev(1,1,1,0,0,0,0,0,0,2'b01,2'b00,1,0,0));
      push("decode", rb(), rb(), rb(), op, ev(0,0,0,0,0,0,0,0,0,2'b10,2'b00,1,0,0));
      case (op)
         OP_R, OP_I: begin
            push(op == OP_R ? "exec_r" : "exec_i", rb(), rb(), rb(), op,
                 ev(0,0,0,0,0,0,0,1,0,(op == OP_R) ? 2'b00 : 2'b10,2'b10,1,0,0));
            push("r_wb", nxt, rb(), rb(), op, ev(0,0,0,0,0,1,0,0,0,2'b00,2'b00,1,0,0));
         end
         OP_LOAD, OP_STORE: begin
            push("mem_addr", rb(), rb(), rb(), op, ev(0,0,0,0,0,0,0,1,0,2'b10,2'b00,1,0,0));
            for (int i = 0; i < mw && i < MAX_WAIT; i++)
               push("mem_wait", rb(), 1'b0, rb(), op,
                    ev(0,0,op == OP_LOAD,op == OP_STORE,1,0,0,0,0,2'b00,2'b00,1,0,0));
            if (mw >= MAX_WAIT) begin
               push_trap(1'b0, 1'b1);
               return;
            end
            if (op == OP_LOAD) begin
               push("mem_rd", rb(), 1'b1, rb(), op, ev(0,0,1,0,1,0,0,0,0,2'b00,2'b00,1,0,0));
               push("mem_wb", nxt, rb(), rb(), op, ev(0,0,0,0,0,1,1,0,0,2'b00,2'b00,1,0,0));
            end else begin
               push("mem_wr", nxt, 1'b1, rb(), op, ev(0,0,0,1,1,0,0,0,0,2'b00,2'b00,1,0,0));
            end
         end
         OP_BRANCH: begin
            push("branch", nxt, rb(), z, op, ev(z,0,0,0,0,0,0,1,1,2'b00,2'b01,1,0,0));
         end
         default: begin
            push_trap(1'b1, 1'b0);
            return;
         end
      endcase
      if (!nxt) begin
         for (int i = 0; i < int'($urandom_range(0, 2)); i++) push_idle(1'b0);
         push_idle(1'b1);
      end
   endfunction

   task automatic run_steps(input int n);
      for (int i = 0; i < n && q.size() > 0; i++) begin
         step_t s;
         s = q.pop_front();
         @(posedge clk);
         #1;
         start     = s.st;
         mem_ready = s.mr;
         zero      = s.z;
         opcode    = s.op;
         @(negedge clk);
         check(s.tag, obs, s.exp);
      end
   endtask

   // Called right after a negedge check, so rst rises mid-cycle with clk low.
   task automatic apply_reset();
      #2;
      rst   = 1'b1;
      start = 1'b0;
      #1 check("reset_async", obs, 16'h0000);
      @(posedge clk);
      #1 check("reset_hold", obs, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [6:0] ops [5];
      ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LOAD; ops[3] = OP_STORE; ops[4] = OP_BRANCH;

      rst = 1'b1; start = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = '0;
      #1 check("reset_init", obs, 16'h0000);
      @(posedge clk);
      #1 check("reset_hold", obs, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      // Directed: R-type, load with 3 waits, two branches, wait-limit edges.
      push_idle(1'b0);
      push_idle(1'b1);
      gen_instr(OP_R, 0, 0, 1'b0, 1'b1);
      gen_instr(OP_LOAD, 0, 3, 1'b0, 1'b1);
      gen_instr(OP_BRANCH, 0, 0, 1'b1, 1'b1);
      gen_instr(OP_BRANCH, 0, 0, 1'b0, 1'b1);
      gen_instr(OP_I, MAX_WAIT - 1, 0, 1'b0, 1'b1);
      gen_instr(OP_LOAD, 1, MAX_WAIT - 1, 1'b0, 1'b1);
      gen_instr(OP_STORE, 0, MAX_WAIT - 1, 1'b0, 1'b0);
      run_steps(q.size());

      // Randomized instruction stream.
      for (int k = 0; k < 200; k++) begin
         int fw, mw;
         fw = ($urandom_range(0, 9) == 0) ? MAX_WAIT - 1 : int'($urandom_range(0, 2));
         mw = ($urandom_range(0, 9) == 0) ? MAX_WAIT - 1 : int'($urandom_range(0, 3));
         gen_instr(ops[$urandom_range(0, 4)], fw, mw, rb(), rb());
      end
      run_steps(q.size());

      // Illegal opcode traps and stays trapped until reset.
      apply_reset();
      push_idle(1'b1);
      gen_instr(OP_BAD, 1, 0, 1'b0, 1'b1);
      run_steps(q.size());

      // Fetch timeout after MAX_WAIT cycles without mem_ready.
      apply_reset();
      push_idle(1'b1);
      gen_instr(OP_R, MAX_WAIT, 0, 1'b0, 1'b1);
      run_steps(q.size());

      // Store timeout in the memory write phase.
      apply_reset();
      push_idle(1'b1);
      gen_instr(OP_STORE, 0, MAX_WAIT, 1'b0, 1'b1);
      run_steps(q.size());

      // Asynchronous reset in the middle of a store wait, then recovery.
      apply_reset();
      push_idle(1'b1);
      gen_instr(OP_STORE, 0, 5, 1'b0, 1'b1);
      run_steps(6);
      q.delete();
      apply_reset();
      push_idle(1'b1);
      gen_instr(OP_LOAD, 2, 2, 1'b0, 1'b0);
      run_steps(q.size());

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t got=running exp=finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
